// File: rtl/buffer_vc_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : buffer_vc_unit                                                   |
// | Purpose  : Per-VC circular flit buffers with a switch-allocator handshake   |
// |            and a req/ack output port. Optional BUFFER_OCCUPANCY_EN adds     |
// |            the vc_count occupancy output.                                   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module buffer_vc_unit #(
    parameter int  DATA_WIDTH = 18,
    parameter int  DEPTH      = 8,
    parameter int  NUM_VC     = 2,
    localparam int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_req,
    input  logic [VC_W-1:0]       in_vc,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ack,
    output logic [NUM_VC-1:0]     vc_full,
    output logic [NUM_VC-1:0]     sa_req,
    input  logic [NUM_VC-1:0]     sa_grant,
    output logic                  out_req,
    output logic [VC_W-1:0]       out_vc,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ack
`ifdef BUFFER_OCCUPANCY_EN
    ,
    output logic [NUM_VC*($clog2(DEPTH)+1)-1:0] vc_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q    [NUM_VC][DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q [NUM_VC];
    logic [PTR_W-1:0]      rd_ptr_q [NUM_VC];
    logic [CNT_W-1:0]      count_q  [NUM_VC];

    logic                  in_ack_q,   in_ack_d;
    logic [NUM_VC-1:0]     sa_req_q,   sa_req_d;
    logic                  out_req_q,  out_req_d;
    logic [VC_W-1:0]       out_vc_q,   out_vc_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic [NUM_VC-1:0]     w_full;
    logic [NUM_VC-1:0]     w_nonempty;
    logic [NUM_VC-1:0]     w_push;
    logic [NUM_VC-1:0]     w_pop;
    logic [NUM_VC-1:0]     w_grant;
    logic                  w_vc_valid;
    logic                  w_target_full;
    logic                  w_accept;
    logic [VC_W-1:0]       w_sel_idx;
    logic [DATA_WIDTH-1:0] w_head;

    // A pop on the same edge frees the slot, so a full VC being popped still accepts.
    always_comb begin
        w_vc_valid    = (int'(in_vc) < NUM_VC);
        w_target_full = 1'b0;
        w_full        = '0;
        w_nonempty    = '0;
        w_pop         = '0;
        w_push        = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            w_nonempty[v] = (count_q[v] != '0);
            w_full[v]     = (count_q[v] == CNT_W'(DEPTH));
            w_pop[v]      = (state_q == SEND) && out_ack &&
                            (out_vc_q == VC_W'(v)) && w_nonempty[v];
            if ((in_vc == VC_W'(v)) && w_full[v] && !w_pop[v]) begin
                w_target_full = 1'b1;
            end
        end
        w_accept = in_req && !in_ack_q && w_vc_valid && !w_target_full;
        for (int v = 0; v < NUM_VC; v++) begin
            w_push[v] = w_accept && (in_vc == VC_W'(v));
        end
        in_ack_d = in_req && !in_ack_q && (!w_vc_valid || !w_target_full);
    end

    // Descending scan so the lowest-index granted VC wins.
    always_comb begin
        w_grant   = sa_grant & sa_req_q;
        w_sel_idx = '0;
        w_head    = '0;
        for (int v = NUM_VC - 1; v >= 0; v--) begin
            if (w_grant[v]) begin
                w_sel_idx = VC_W'(v);
                w_head    = mem_q[v][rd_ptr_q[v]];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sa_req_d   = sa_req_q;
        out_req_d  = out_req_q;
        out_vc_d   = out_vc_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                sa_req_d = w_nonempty;
                if (|w_nonempty) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (|w_grant) begin
                    out_data_d = w_head;
                    out_vc_d   = w_sel_idx;
                    out_req_d  = 1'b1;
                    sa_req_d   = '0;
                    state_d    = SEND;
                end else begin
                    sa_req_d = w_nonempty;
                end
            end
            SEND: begin
                if (out_ack) begin
                    out_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ack_q   <= 1'b0;
            sa_req_q   <= '0;
            out_req_q  <= 1'b0;
            out_vc_q   <= '0;
            out_data_q <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            in_ack_q   <= in_ack_d;
            sa_req_q   <= sa_req_d;
            out_req_q  <= out_req_d;
            out_vc_q   <= out_vc_d;
            out_data_q <= out_data_d;
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_push[v]) begin
                    wr_ptr_q[v] <= wr_ptr_q[v] + PTR_W'(1);
                end
                if (w_pop[v]) begin
                    rd_ptr_q[v] <= rd_ptr_q[v] + PTR_W'(1);
                end
                count_q[v] <= count_q[v] + CNT_W'(w_push[v]) - CNT_W'(w_pop[v]);
            end
        end
    end

    // Storage is not reset; cleared pointers make old contents unreachable.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (!rst && w_push[v]) begin
                mem_q[v][wr_ptr_q[v]] <= in_data;
            end
        end
    end

    assign in_ack   = in_ack_q;
    assign vc_full  = w_full;
    assign sa_req   = sa_req_q;
    assign out_req  = out_req_q;
    assign out_vc   = out_vc_q;
    assign out_data = out_data_q;

`ifdef BUFFER_OCCUPANCY_EN
    generate
        for (genvar gv = 0; gv < NUM_VC; gv++) begin : g_vc_count
            assign vc_count[gv*CNT_W +: CNT_W] = count_q[gv];
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_buffer_vc_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_buffer_vc_unit                                                |
// | Purpose  : Self-checking bench for buffer_vc_unit (queue-based model).      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_buffer_vc_unit;

    localparam int DW    = 18;
    localparam int DEPTH = 8;
    localparam int NVC   = 3;
    localparam int VW    = 2;
    localparam int CW    = 4;

    logic           clk      = 1'b0;
    logic           rst      = 1'b1;
    logic           in_req   = 1'b0;
    logic [VW-1:0]  in_vc    = '0;
    logic [DW-1:0]  in_data  = '0;
    logic           in_ack;
    logic [NVC-1:0] vc_full;
    logic [NVC-1:0] sa_req;
    logic [NVC-1:0] sa_grant = '0;
    logic           out_req;
    logic [VW-1:0]  out_vc;
    logic [DW-1:0]  out_data;
    logic           out_ack  = 1'b0;
`ifdef BUFFER_OCCUPANCY_EN
    logic [NVC*CW-1:0] vc_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    buffer_vc_unit #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .NUM_VC    (NVC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_req   (in_req),
        .in_vc    (in_vc),
        .in_data  (in_data),
        .in_ack   (in_ack),
        .vc_full  (vc_full),
        .sa_req   (sa_req),
        .sa_grant (sa_grant),
        .out_req  (out_req),
        .out_vc   (out_vc),
        .out_data (out_data),
        .out_ack  (out_ack)
`ifdef BUFFER_OCCUPANCY_EN
        ,
        .vc_count (vc_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per VC, plus the handshake outputs it implies.
    logic [DW-1:0]  mq [NVC][$];
    bit             m_valid = 1'b0;
    bit             m_ack   = 1'b0;
    bit             m_oreq  = 1'b0;
    logic [NVC-1:0] m_sareq = '0;
    int             m_ovc   = 0;
    logic [DW-1:0]  m_odata = '0;
    int             m_phase = 0;   // 0 idle, 1 arbitrating, 2 presenting

    always @(posedge clk) begin : model
        int             popv;
        int             sel;
        bit             nack;
        logic [NVC-1:0] ne;
        logic [NVC-1:0] g;
        if (rst) begin
            for (int v = 0; v < NVC; v++) mq[v].delete();
            m_ack = 0; m_oreq = 0; m_sareq = '0; m_ovc = 0; m_odata = '0;
            m_phase = 0; m_valid = 1;
        end else if (m_valid) begin
            popv = (m_phase == 2 && out_ack) ? m_ovc : -1;
            ne = '0;
            for (int v = 0; v < NVC; v++) ne[v] = (mq[v].size() != 0);
            nack = 0;
            if (in_req && !m_ack) begin
                if (int'(in_vc) >= NVC) nack = 1;
                else if (mq[in_vc].size() < DEPTH || popv == int'(in_vc)) nack = 1;
            end
            case (m_phase)
                0: begin
                    m_sareq = ne;
                    if (ne != 0) m_phase = 1;
                end
                1: begin
                    g = sa_grant & m_sareq;
                    if (g != 0) begin
                        sel = 0;
                        while (!g[sel]) sel++;
                        m_odata = mq[sel][0];
                        m_ovc   = sel;
                        m_oreq  = 1;
                        m_sareq = '0;
                        m_phase = 2;
                    end else begin
                        m_sareq = ne;
                    end
                end
                default: begin
                    if (out_ack) begin
                        void'(mq[m_ovc].pop_front());
                        m_oreq  = 0;
                        m_phase = 0;
                    end
                end
            endcase
            if (nack && int'(in_vc) < NVC) mq[in_vc].push_back(in_data);
            m_ack = nack;
        end
    end

    always @(negedge clk) begin : compare
        logic [NVC-1:0]    efull;
        logic [NVC*CW-1:0] ecnt;
        if (m_valid) begin
            for (int v = 0; v < NVC; v++) begin
                efull[v]          = (mq[v].size() == DEPTH);
                ecnt[v*CW +: CW]  = CW'(mq[v].size());
            end
            check("in_ack",   32'(in_ack),   32'(m_ack));
            check("sa_req",   32'(sa_req),   32'(m_sareq));
            check("out_req",  32'(out_req),  32'(m_oreq));
            check("out_vc",   32'(out_vc),   32'(m_ovc));
            check("out_data", 32'(out_data), 32'(m_odata));
            check("vc_full",  32'(vc_full),  32'(efull));
`ifdef BUFFER_OCCUPANCY_EN
            check("vc_count", 32'(vc_count), 32'(ecnt));
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; in_req = 0; sa_grant = '0; out_ack = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic push(input int vc, input logic [DW-1:0] d);
        in_req = 1; in_vc = VW'(vc); in_data = d;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (in_ack) begin
                in_req = 0;
                return;
            end
        end
        in_req = 0;
        check("push_timeout", 32'(in_ack), 32'h1);
    endtask

    task automatic pop_one(input logic [NVC-1:0] gnt, output logic [DW-1:0] d, output int vc);
        sa_grant = gnt; d = '0; vc = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_req) begin
                sa_grant = '0;
                d = out_data; vc = int'(out_vc);
                out_ack = 1;
                tick();
                out_ack = 0;
                return;
            end
        end
        sa_grant = '0;
        check("pop_timeout", 32'(out_req), 32'h1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [DW-1:0] d;
        int            vc;
        int            exp_q [$];
        bit            seen;

        // Single flit
        do_reset();
        check("rst_in_ack",   32'(in_ack),   32'h0);
        check("rst_sa_req",   32'(sa_req),   32'h0);
        check("rst_out_req",  32'(out_req),  32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_vc_full",  32'(vc_full),  32'h0);
        in_req = 1; in_vc = 0; in_data = 18'd347;
        tick();
        check("t1_ack", 32'(in_ack), 32'h1);
        in_req = 0;
        tick();
        check("t1_sa_req", 32'(sa_req), 32'h1);
        sa_grant = 3'b001;
        tick();
        sa_grant = '0;
        check("t1_out_req",  32'(out_req),  32'h1);
        check("t1_out_vc",   32'(out_vc),   32'h0);
        check("t1_out_data", 32'(out_data), 32'd347);
        out_ack = 1;
        tick();
        out_ack = 0;
        check("t1_out_req_drop", 32'(out_req), 32'h0);
        check("t1_sa_req_drop",  32'(sa_req),  32'h0);

        // Fill VC1, then a 9th waits for a slot
        for (int i = 1; i <= 8; i++) push(1, DW'(i));
        tick();
        check("fill_full", 32'(vc_full), 32'h2);
        in_req = 1; in_vc = 1; in_data = 18'd9;
        repeat (3) tick();
        check("fill_no_ack", 32'(in_ack), 32'h0);
        sa_grant = 3'b010;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (out_req) seen = 1;
        end
        check("fill_out_req", 32'(out_req), 32'h1);
        sa_grant = '0;
        d = out_data;
        out_ack = 1;
        tick();
        out_ack = 0;
        check("fill_ack9", 32'(in_ack), 32'h1);
        in_req = 0;
        check("fill_first", 32'(d), 32'h1);
        for (int k = 2; k <= 9; k++) begin
            pop_one(3'b010, d, vc);
            check("fill_order", 32'(d), 32'(k));
        end

        // Contention: lowest granted VC first
        push(0, 18'hA);
        push(1, 18'hB);
        for (int i = 0; i < 10 && sa_req != 3'b011; i++) tick();
        check("cont_sa_req", 32'(sa_req), 32'h3);
        pop_one(3'b011, d, vc);
        check("cont_first_data", 32'(d), 32'hA);
        check("cont_first_vc",   32'(vc), 32'h0);
        pop_one(3'b010, d, vc);
        check("cont_second_data", 32'(d), 32'hB);
        check("cont_second_vc",   32'(vc), 32'h1);

        // Invalid VC is acked and dropped
        push(3, 18'h55);
        repeat (3) tick();
        check("inv_sa_req",  32'(sa_req),  32'h0);
        check("inv_vc_full", 32'(vc_full), 32'h0);
        check("inv_out_req", 32'(out_req), 32'h0);

        // Reset while presenting
        push(2, 18'h77);
        sa_grant = 3'b100;
        for (int i = 0; i < 20 && !out_req; i++) tick();
        sa_grant = '0;
        check("mid_out_req", 32'(out_req), 32'h1);
        rst = 1; in_req = 1; in_vc = 0; in_data = 18'h123;
        tick();
        rst = 0; in_req = 0;
        check("mid_rst_out_req",  32'(out_req),  32'h0);
        check("mid_rst_sa_req",   32'(sa_req),   32'h0);
        check("mid_rst_vc_full",  32'(vc_full),  32'h0);
        check("mid_rst_in_ack",   32'(in_ack),   32'h0);
        check("mid_rst_out_data", 32'(out_data), 32'h0);
`ifdef BUFFER_OCCUPANCY_EN
        check("mid_rst_vc_count", 32'(vc_count), 32'h0);
`endif

        // Pointer wrap through VC0
        for (int i = 0; i < 4; i++) begin
            push(0, DW'(200 + i));
            exp_q.push_back(200 + i);
        end
        for (int i = 4; i < 20; i++) begin
            push(0, DW'(200 + i));
            exp_q.push_back(200 + i);
            pop_one(3'b001, d, vc);
            check("wrap_data", 32'(d), 32'(exp_q.pop_front()));
        end
        while (exp_q.size() != 0) begin
            pop_one(3'b001, d, vc);
            check("wrap_tail", 32'(d), 32'(exp_q.pop_front()));
        end

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 399) == 0);
            in_req   = ($urandom_range(0, 2) != 0);
            in_vc    = VW'($urandom_range(0, 3));
            in_data  = DW'($urandom);
            sa_grant = NVC'($urandom);
            out_ack  = (c < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            tick();
        end
        rst = 0; in_req = 0; sa_grant = '0; out_ack = 0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/buffer_vc_unit.md
BUFFER_VC_UNIT -- requirements
Module: buffer_vc_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18, flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, flits per virtual channel (VC), power of two, at least 2.
REQ-003 SHALL have parameter NUM_VC, default 2, number of VCs, at least 1; VC_W = max(1, clog2(NUM_VC)).
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_req  in  1  upstream flit request.
- in_vc  in  VC_W  target VC of the flit.
- in_data  in  DATA_WIDTH  flit payload.
- in_ack  out  1  one-cycle acceptance pulse.
- vc_full  out  NUM_VC  per-VC full flag, combinational from occupancy.
- sa_req  out  NUM_VC  per-VC switch-allocator request.
- sa_grant  in  NUM_VC  switch-allocator grant.
- out_req  out  1  downstream flit request.
- out_vc  out  VC_W  VC of the presented flit.
- out_data  out  DATA_WIDTH  presented flit.
- out_ack  in  1  downstream acceptance.

Function
REQ-005 SHALL hold an independent circular FIFO per VC with a write pointer, a read pointer and a count of width clog2(DEPTH)+1; pointers wrap from DEPTH-1 to 0.
REQ-006 SHALL treat a cycle as an input accept when in_req=1, in_ack=0, in_vc<NUM_VC and vc_full[in_vc]=0; on that edge it writes in_data and asserts in_ack for exactly the next cycle.
REQ-007 SHALL, when in_req=1 and in_vc>=NUM_VC, pulse in_ack and discard the flit with no state change.
REQ-008 SHALL withhold in_ack while the target VC is full and accept on the first cycle a slot frees; in_req held high after an ack cycle counts as a new request, so peak input rate is one flit per 2 cycles.
REQ-009 SHALL run an output FSM with states IDLE, ARB and SEND.
REQ-010 SHALL, in IDLE, set sa_req[v]=1 for every non-empty VC v and move to ARB when any VC is non-empty.
REQ-011 SHALL, in ARB, sample sa_grant masked by sa_req; on a non-zero grant select the lowest-index granted VC, register its head flit into out_data/out_vc, set out_req=1, clear sa_req and enter SEND; with no valid grant stay in ARB and keep sa_req updated.
REQ-012 SHALL, in SEND, hold out_req, out_data and out_vc stable until out_ack=1; on that edge pop the selected VC, drop out_req and return to IDLE, giving at most one flit per 3 cycles.
REQ-013 SHALL ignore sa_grant outside ARB and ignore out_ack outside SEND.
REQ-014 SHALL, on a simultaneous push and pop to the same VC, leave its count unchanged, including when the VC is full, because the pop is evaluated first for vc_full.
REQ-015 SHALL never pop an empty VC or push a full VC.

Reset
REQ-016 SHALL, with rst=1 at a rising edge, clear all pointers and counts and force state IDLE, in_ack=0, sa_req=0, out_req=0, out_vc=0, out_data=0, so that vc_full=0.
REQ-017 SHALL, on reset mid-transfer, discard all stored flits and any flit being presented, with no ack generated in the reset cycle.

Configuration
REQ-018 SHALL, when macro BUFFER_OCCUPANCY_EN is defined, add output vc_count (NUM_VC*(clog2(DEPTH)+1) bits, VC0 in the LSBs) reporting each VC's registered count, reset to 0.
REQ-019 SHALL, without BUFFER_OCCUPANCY_EN, omit vc_count entirely with all other behaviour identical.

Verification
REQ-020 Single flit: reset, send in_vc=0 with in_data=347 -> in_ack pulses 1 cycle later; sa_req=01; grant 01 -> out_req=1, out_vc=0, out_data=347; out_ack -> out_req=0, sa_req=00.
REQ-021 Fill: with DEPTH=8, push 8 flits (1..8) to VC1 with no grants -> vc_full=10 and a 9th request is not acked; one pop -> 9th acked; output order is 1..9.
REQ-022 Contention: one flit each in VC0 (0xA) and VC1 (0xB); grant 11 -> VC0 is sent first (0xA); then grant 10 -> 0xB is sent.
REQ-023 Invalid VC: with NUM_VC=3, in_vc=3 -> acked, no sa_req change, counts stay 0.
REQ-024 Reset mid-SEND: out_req=1, assert rst for 1 cycle -> out_req=0, sa_req=0, vc_full=0, and vc_count=0 when BUFFER_OCCUPANCY_EN is defined.
REQ-025 Wrap: push and pop 20 flits through VC0 (DEPTH=8) -> data order preserved across pointer wrap, with no spurious full.
